// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core widths and the fetch FIFO entry type
package riscv_pkg;
    localparam int XLEN        = 64;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with push/pop/flush, occupancy count and full/empty flags
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = XLEN + ILEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    // Pointers and count; flush empties the queue like reset does.
    always_ff @(posedge clk)
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues aligned fetches, buffers in-order responses, flushes on redirect
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc
);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] pc, resp_pc, redirect_aligned;
    logic [CW-1:0]   outstanding, drop_cnt, fifo_count;
    logic            hs, rsp_ok, push, pop, empty, full;
    fetch_entry_t    head, tail;

    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    assign imem_req_valid   = !rst && !redirect_valid &&
                              ({1'b0, fifo_count} + {1'b0, outstanding} < (CW+1)'(DEPTH));
    assign imem_req_addr    = pc;
    assign hs               = imem_req_valid && imem_req_ready;
    assign rsp_ok           = imem_rsp_valid && outstanding != '0;
    assign push             = rsp_ok && drop_cnt == '0 && !redirect_valid;
    assign pop              = if_valid && if_ready && !redirect_valid;
    assign if_valid         = !rst && !empty;
    assign if_instr         = head.instr;
    assign if_pc            = head.pc;
    assign tail             = '{pc: resp_pc, instr: imem_rsp_data};

    fetch_fifo #(.DEPTH(DEPTH), .W(XLEN + ILEN)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (tail),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // Fetch PC, response PC and in-flight/drop accounting; a redirect makes every
    // request still in flight stale, so drop_cnt never exceeds outstanding.
    always_ff @(posedge clk)
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(hs) - CW'(rsp_ok);
            drop_cnt    <= redirect_valid ? outstanding - CW'(rsp_ok)
                                          : drop_cnt - CW'(rsp_ok && drop_cnt != '0);
            pc          <= redirect_valid ? redirect_aligned
                                          : hs ? pc + XLEN'(INSTR_BYTES) : pc;
            resp_pc     <= redirect_valid ? redirect_aligned
                                          : push ? resp_pc + XLEN'(INSTR_BYTES) : resp_pc;
        end

    // Flag responses with nothing in flight and any push the credit scheme should prevent.
    always_ff @(posedge clk)
        if (!rst) begin
            if (imem_rsp_valid) assert (outstanding != '0);
            if (push) assert (!full || pop);
        end
endmodule
